// File: rtl/protocol_pkg.sv
// rtl/protocol_pkg.sv - shared widths, derived counts and tx state type
package protocol_pkg;

  localparam int DATA_LINE_WIDTH    = 64;
  localparam int CONTROL_LINE_WIDTH = 6;
  localparam int FLIT_WIDTH         = 16;
  localparam int PACKET_WIDTH       = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH;
  localparam int NUM_DATA_FLITS     = DATA_LINE_WIDTH / FLIT_WIDTH;
  localparam int BEAT_WIDTH         = $clog2(NUM_DATA_FLITS + 2);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HDR,
    DATA,
    CSUM
  } tx_state_t;

endpackage

// File: rtl/fifo_packet_tx_if.sv
// rtl/fifo_packet_tx_if.sv - FIFO read side plus flit link bundle
interface fifo_packet_tx_if;
  import protocol_pkg::*;

  logic                    i_fifo_empty;
  logic [PACKET_WIDTH-1:0] i_fifo_packet;
  logic                    o_fifo_read_en;
  logic [FLIT_WIDTH-1:0]   o_flit;
  logic                    o_flit_valid;
  logic                    i_flit_ready;
  logic                    o_flit_first;
  logic                    o_flit_last;

  // Transmitter side: pops the FIFO and drives the link.
  modport master (
    input  i_fifo_empty,
    input  i_fifo_packet,
    input  i_flit_ready,
    output o_fifo_read_en,
    output o_flit,
    output o_flit_valid,
    output o_flit_first,
    output o_flit_last
  );

  // FIFO and sink side.
  modport slave (
    output i_fifo_empty,
    output i_fifo_packet,
    output i_flit_ready,
    input  o_fifo_read_en,
    input  o_flit,
    input  o_flit_valid,
    input  o_flit_first,
    input  o_flit_last
  );

endinterface

// File: rtl/fifo_packet_tx_flit_xor_accum.sv
// rtl/fifo_packet_tx_flit_xor_accum.sv - running XOR over accepted flits
module flit_xor_accum
  import protocol_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic [FLIT_WIDTH-1:0] flit_i,
  output logic [FLIT_WIDTH-1:0] acc_o
);

  logic [FLIT_WIDTH-1:0] acc_q;

  // Clear takes priority so a fresh packet never inherits the old sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q ^ flit_i;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fifo_packet_tx.sv
// rtl/fifo_packet_tx.sv - FIFO packet to flit serializer; option macro PACKET_TX_CHECKSUM_EN
module fifo_packet_tx
  import protocol_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_packet_tx_if.master     tx,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_pkt_count
);

  tx_state_t               state_q, state_d;
  logic [PACKET_WIDTH-1:0] hold_q, hold_d;
  logic [BEAT_WIDTH-1:0]   beat_q, beat_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_LINE_WIDTH-1:0] data_shift;
  logic                    last_beat;

  // Current data slice: least significant slice goes out first.
  assign data_shift = hold_q[DATA_LINE_WIDTH-1:0] >> (FLIT_WIDTH * int'(beat_q));
  assign last_beat  = (beat_q == BEAT_WIDTH'(NUM_DATA_FLITS - 1));

`ifdef PACKET_TX_CHECKSUM_EN
  logic                  accept;
  logic [FLIT_WIDTH-1:0] csum;

  assign accept = tx.o_flit_valid && tx.i_flit_ready;

  // Header and data flits feed the sum; the checksum flit itself does not.
  flit_xor_accum u_xor_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (state_q == LOAD),
    .en_i    (accept && (state_q != CSUM)),
    .flit_i  (tx.o_flit),
    .acc_o   (csum)
  );
`endif

  // State, holding register, beat index and packet counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and link outputs; outputs depend only on registered state so they hold during stalls.
  always_comb begin
    state_d           = state_q;
    hold_d            = hold_q;
    beat_d            = beat_q;
    cnt_d             = cnt_q;
    tx.o_fifo_read_en = 1'b0;
    tx.o_flit_valid   = 1'b0;
    tx.o_flit         = '0;
    tx.o_flit_first   = 1'b0;
    tx.o_flit_last    = 1'b0;
    case (state_q)
      IDLE: begin
        tx.o_fifo_read_en = !tx.i_fifo_empty;
        if (!tx.i_fifo_empty) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        hold_d  = tx.i_fifo_packet;
        state_d = HDR;
      end
      HDR: begin
        tx.o_flit_valid = 1'b1;
        tx.o_flit_first = 1'b1;
        tx.o_flit       = FLIT_WIDTH'(hold_q[PACKET_WIDTH-1 -: CONTROL_LINE_WIDTH]);
        if (tx.i_flit_ready) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end
      DATA: begin
        tx.o_flit_valid = 1'b1;
        tx.o_flit       = data_shift[FLIT_WIDTH-1:0];
`ifndef PACKET_TX_CHECKSUM_EN
        tx.o_flit_last  = last_beat;
`endif
        if (tx.i_flit_ready) begin
          if (last_beat) begin
`ifdef PACKET_TX_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = IDLE;
            cnt_d   = cnt_q + CNT_WIDTH'(1);
`endif
          end else begin
            beat_d = beat_q + BEAT_WIDTH'(1);
          end
        end
      end
      CSUM: begin
`ifdef PACKET_TX_CHECKSUM_EN
        tx.o_flit_valid = 1'b1;
        tx.o_flit_last  = 1'b1;
        tx.o_flit       = csum;
        if (tx.i_flit_ready) begin
          state_d = IDLE;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy      = (state_q != IDLE);
  assign o_pkt_count = cnt_q;

endmodule

// File: tb/tb_fifo_packet_tx.sv
// tb/tb_fifo_packet_tx.sv - randomized bench with a flit-sequence reference model
module tb_fifo_packet_tx;

  localparam int CW = 4;
`ifdef PACKET_TX_CHECKSUM_EN
  localparam int NF      = 6;
  localparam bit CSUM_ON = 1'b1;
`else
  localparam int NF      = 5;
  localparam bit CSUM_ON = 1'b0;
`endif

  typedef struct {
    logic [15:0] f;
    logic        first;
    logic        last;
    int          cyc;
  } flit_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy;
  logic [CW-1:0] pkt_count;

  fifo_packet_tx_if bus();

  fifo_packet_tx #(.CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx          (bus.master),
    .o_busy      (busy),
    .o_pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  logic [69:0] mem [64];
  int          wr = 0;
  int          rd = 0;
  logic [69:0] rdata = '0;
  bit          pop_pending = 1'b0;
  bit          force_empty = 1'b0;
  bit          force_next = 1'b0;
  logic        ready = 1'b0;
  logic [69:0] stage [$];

  assign bus.i_fifo_empty  = (wr == rd) || force_empty;
  assign bus.i_fifo_packet = rdata;
  assign bus.i_flit_ready  = ready;

  // FIFO with registered read data: valid the cycle after the pop.
  always @(posedge clk) begin
    if (pop_pending) begin
      rdata <= mem[rd % 64];
      rd    <= rd + 1;
    end
  end

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          rd_pulses = 0;
  int          mcnt = 0;
  bit          in_flight = 1'b0;
  int          ready_mode = 0;
  flit_t       exp_q [$];
  flit_t       log_q [$];
  bit          prev_stall = 1'b0;
  logic [15:0] prev_flit = '0;
  logic        prev_first = 1'b0;
  logic        prev_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Expected flit stream of one packet: header, data slices LS first, optional XOR.
  task automatic expect_pkt(input logic [69:0] p);
    flit_t       e;
    logic [15:0] s;
    logic [15:0] x;
    s = {10'b0, p[69:64]};
    x = s;
    e.f = s; e.first = 1'b1; e.last = 1'b0; e.cyc = 0;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      s = p[16*i +: 16];
      x = x ^ s;
      e.f = s; e.first = 1'b0; e.last = !CSUM_ON && (i == 3);
      exp_q.push_back(e);
    end
    if (CSUM_ON) begin
      e.f = x; e.first = 1'b0; e.last = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic model_step();
    flit_t e;
    flit_t l;
    if (!rst_n) begin
      exp_q.delete();
      in_flight   = 1'b0;
      mcnt        = 0;
      pop_pending = 1'b0;
      prev_stall  = 1'b0;
      return;
    end
    chk("read_en", bus.o_fifo_read_en, !bus.i_fifo_empty && !in_flight);
    chk("busy", busy, in_flight);
    chk("pkt_count", pkt_count, mcnt[CW-1:0]);
    if (prev_stall) begin
      chk("stall_valid", bus.o_flit_valid, 1);
      chk("stall_flit", {bus.o_flit_first, bus.o_flit_last, bus.o_flit},
          {prev_first, prev_last, prev_flit});
    end
    if (bus.o_flit_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", bus.o_flit_valid, 0);
      end else begin
        e = exp_q[0];
        chk("flit", bus.o_flit, e.f);
        chk("first", bus.o_flit_first, e.first);
        chk("last", bus.o_flit_last, e.last);
      end
    end
    prev_stall  = bus.o_flit_valid && !ready;
    prev_flit   = bus.o_flit;
    prev_first  = bus.o_flit_first;
    prev_last   = bus.o_flit_last;
    pop_pending = bus.o_fifo_read_en;
    if (bus.o_fifo_read_en) begin
      rd_pulses++;
      expect_pkt(mem[rd % 64]);
      in_flight = 1'b1;
    end
    if (bus.o_flit_valid && ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      l.f = bus.o_flit; l.first = bus.o_flit_first; l.last = bus.o_flit_last; l.cyc = cyc;
      log_q.push_back(l);
      if (e.last) begin
        mcnt++;
        in_flight = 1'b0;
      end
    end
  endtask

  // Inputs change just after the rising edge; the model samples on the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    while (stage.size() > 0) begin
      mem[wr % 64] = stage.pop_front();
      wr++;
    end
    force_empty = force_next;
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: ready = ($urandom % 4) != 0;
    endcase
    @(negedge clk);
    model_step();
    cyc++;
  endtask

  task automatic wait_flits(input int n, input int budget);
    int k;
    k = 0;
    while (log_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    chk("wait_flits_timeout", log_q.size() >= n, 1);
    cycle();
  endtask

  function automatic logic [69:0] rand_pkt();
    return {6'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  initial begin
    logic [69:0] p;
    logic [15:0] ref_flits [6];
    int          b;
    int          p0;
    int          k;
    p = {6'h2A, 64'h1122_3344_5566_7788};
    ref_flits = '{16'h002A, 16'h7788, 16'h5566, 16'h3344, 16'h1122, 16'h00A2};

    repeat (3) cycle();
    chk("rst_valid", bus.o_flit_valid, 0);
    chk("rst_flit", bus.o_flit, 0);
    chk("rst_first", bus.o_flit_first, 0);
    chk("rst_last", bus.o_flit_last, 0);
    chk("rst_read_en", bus.o_fifo_read_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", pkt_count, 0);
    rst_n = 1'b1;

    // Single packet, sink always ready.
    ready_mode = 0;
    b  = log_q.size();
    p0 = rd_pulses;
    stage.push_back(p);
    wait_flits(b + NF, 100);
    for (int i = 0; i < NF; i++) begin
      chk("t1_flit", log_q[b+i].f, ref_flits[i]);
      chk("t1_first", log_q[b+i].first, i == 0);
      chk("t1_last", log_q[b+i].last, i == NF - 1);
    end
`ifdef PACKET_TX_CHECKSUM_EN
    chk("t1_csum", log_q[b+5].f, 16'h00A2);
    chk("t1_data_last_low", log_q[b+4].last, 0);
`else
    chk("t1_data_last", log_q[b+4].last, 1);
`endif
    chk("t1_read_pulses", rd_pulses - p0, 1);
    chk("t1_count", pkt_count, 1);

    // Same packet, ready toggling 1-0-0-1.
    ready_mode = 1;
    b = log_q.size();
    stage.push_back(p);
    wait_flits(b + NF, 200);
    for (int i = 0; i < NF; i++) chk("t2_flit", log_q[b+i].f, ref_flits[i]);
    chk("t2_count", pkt_count, 2);

    // Two packets queued back to back.
    ready_mode = 0;
    b = log_q.size();
    stage.push_back(rand_pkt());
    stage.push_back(rand_pkt());
    wait_flits(b + 2 * NF, 200);
    chk("b2b_gap", log_q[b+NF].cyc - log_q[b+NF-1].cyc, 3);
    chk("b2b_first", log_q[b+NF].first, 1);
    chk("b2b_count", pkt_count, 4);

    // Reset in the middle of a packet.
    b = log_q.size();
    stage.push_back(p);
    wait_flits(b + 3, 100);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.o_flit_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", pkt_count, 0);
    chk("mid_rst_read_en", bus.o_fifo_read_en, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    b = log_q.size();
    stage.push_back(p);
    wait_flits(b + NF, 100);
    chk("post_rst_hdr", log_q[b].f, 16'h002A);
    chk("post_rst_first", log_q[b].first, 1);
    chk("post_rst_count", pkt_count, 1);

    // Random traffic, random ready, random empty glitches.
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if (($urandom % 3) == 0 && (wr - rd + stage.size()) < 40) stage.push_back(rand_pkt());
      force_next = ($urandom % 8) == 0;
      cycle();
    end
    force_next = 1'b0;
    k = 0;
    while ((wr != rd || in_flight) && k < 1000) begin
      cycle();
      k++;
    end
    chk("drain", (wr == rd) && !in_flight, 1);

    // Counter wrap with a 4-bit counter.
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    b = log_q.size();
    for (int i = 0; i < 15; i++) stage.push_back(rand_pkt());
    wait_flits(b + 15 * NF, 2000);
    chk("wrap_15", pkt_count, 15);
    stage.push_back(rand_pkt());
    wait_flits(b + 16 * NF, 300);
    chk("wrap_0", pkt_count, 0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("empty_read_en", bus.o_fifo_read_en, 0);
      chk("empty_busy", busy, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
